// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } scan_state_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Indexed [row][col]; row 3 follows the board silkscreen, not hex order.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic is_onehot_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Position of the (last) zero bit; meaningful only for one-hot-low input.
    function automatic logic [1:0] zero_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_divider.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks.
module tick_divider #(
    parameter int SCAN_DIV = 40000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with column synchronizer, press/release debounce and hex output.
// Optional KEYPAD_HISTORY_EN adds prev_key, the code accepted before the current key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 40000,
    parameter int DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_n,
    output logic [3:0] rows_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
`ifdef KEYPAD_HISTORY_EN
    ,
    output logic [3:0] prev_key
`endif
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_TICKS);

    logic [3:0]  sync1, sync2, cols_s;
    logic        tick;
    scan_state_t state;
    logic [7:0]  count;
    logic [1:0]  cap_col;
    logic        col_ok, same_col, cap_high, deb_done;
    logic [1:0]  col_idx, row_idx;
    logic [3:0]  rows_rot;
    logic        accept, release_done;

    tick_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // cols_n is asynchronous to clk; nothing downstream looks at it unsynchronized.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= cols_n;
            sync2 <= sync1;
        end
    end

    assign cols_s   = sync2;
    assign col_ok   = is_onehot_low(cols_s);
    assign col_idx  = zero_index(cols_s);
    assign row_idx  = zero_index(rows_n);
    assign same_col = col_ok && (col_idx == cap_col);
    assign cap_high = cols_s[cap_col];
    assign rows_rot = {rows_n[2:0], rows_n[3]};
    assign deb_done = ((count + 8'd1) == DEB_LAST);

    always_comb begin
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            case (state)
                SCAN:      accept       = col_ok && (DEB_TICKS == 1);
                DEB_PRESS: accept       = same_col && deb_done;
                HELD:      release_done = cap_high && (DEB_TICKS == 1);
                DEB_REL:   release_done = cap_high && deb_done;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            rows_n  <= ROW_RESET;
            count   <= 8'd0;
            cap_col <= 2'd0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (col_ok) begin
                        cap_col <= col_idx;
                        count   <= 8'd1;
                        state   <= (DEB_TICKS > 1) ? DEB_PRESS : HELD;
                    end else begin
                        rows_n <= rows_rot;
                    end
                end
                DEB_PRESS: begin
                    if (same_col) begin
                        count <= count + 8'd1;
                        if (accept) state <= HELD;
                    end else begin
                        state  <= SCAN;
                        rows_n <= rows_rot;
                    end
                end
                HELD: begin
                    // Only the captured column of the frozen row matters here,
                    // so a second key elsewhere cannot disturb the hold.
                    if (cap_high) begin
                        count <= 8'd1;
                        if (release_done) begin
                            state  <= SCAN;
                            rows_n <= rows_rot;
                        end else begin
                            state <= DEB_REL;
                        end
                    end
                end
                DEB_REL: begin
                    if (!cap_high) begin
                        state <= HELD;
                    end else begin
                        count <= count + 8'd1;
                        if (release_done) begin
                            state  <= SCAN;
                            rows_n <= rows_rot;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_HISTORY_EN
            prev_key  <= 4'h0;
`endif
        end else begin
            key_valid <= accept;
            if (accept) begin
                key      <= KEYMAP[row_idx][col_idx];
                key_held <= 1'b1;
`ifdef KEYPAD_HISTORY_EN
                prev_key <= key;
`endif
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a streak-counting keypad model checked every cycle.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
`ifdef KEYPAD_HISTORY_EN
    logic [3:0]  prev_key;
`endif

    logic [15:0] pressed;
    logic        glitch;
    logic        run;
    int          checks = 0;
    int          passes = 0;
    int          pulses = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (
        .clk      (clk),
        .reset    (reset),
        .cols_n   (cols_n),
        .rows_n   (rows_n),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held)
`ifdef KEYPAD_HISTORY_EN
        ,
        .prev_key (prev_key)
`endif
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols_n = 4'b1111;
        if (!glitch) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c] && !rows_n[r]) cols_n[c] = 1'b0;
        end
    end

    // Behavioural model: row index, press streak and release streak counters.
    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    int         m_div, m_row, m_col, m_streak, m_rel;
    logic       m_held, m_valid;
    logic [3:0] m_key, m_prev, m_s1, m_s2;

    always @(posedge clk or posedge reset) begin : model
        logic [3:0] cs, k, pk;
        logic       tk, held, valid;
        int         nz, zc, row, col, streak, rel;
        if (reset) begin
            m_div <= 0; m_row <= 0; m_col <= 0; m_streak <= 0; m_rel <= 0;
            m_held <= 1'b0; m_valid <= 1'b0; m_key <= 4'h0; m_prev <= 4'h0;
            m_s1 <= 4'hF; m_s2 <= 4'hF;
        end else begin
            row = m_row; col = m_col; streak = m_streak; rel = m_rel;
            held = m_held; k = m_key; pk = m_prev; valid = 1'b0;
            cs = m_s2;
            tk = (m_div == SD - 1);
            nz = 0; zc = 0;
            for (int i = 0; i < 4; i++) if (!cs[i]) begin nz++; zc = i; end
            if (tk) begin
                if (!held) begin
                    if (streak == 0) begin
                        if (nz == 1) begin col = zc; streak = 1; end
                        else row = (row + 1) % 4;
                    end else if (nz == 1 && zc == col) begin
                        streak++;
                    end else begin
                        streak = 0; row = (row + 1) % 4;
                    end
                    if (streak == DT) begin
                        pk = k; k = km[row*4+col]; valid = 1'b1;
                        held = 1'b1; streak = 0; rel = 0;
                    end
                end else if (cs[col]) begin
                    rel++;
                    if (rel == DT) begin held = 1'b0; rel = 0; row = (row + 1) % 4; end
                end else begin
                    rel = 0;
                end
            end
            m_div <= tk ? 0 : m_div + 1;
            m_s2 <= m_s1; m_s1 <= cols_n;
            m_row <= row; m_col <= col; m_streak <= streak; m_rel <= rel;
            m_held <= held; m_valid <= valid; m_key <= k; m_prev <= pk;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : compare
        logic [3:0] er;
        if (run) begin
            er = ~(4'b0001 << m_row);
            chk("rows_n", {4'h0, rows_n}, {4'h0, er});
            chk("key", {4'h0, key}, {4'h0, m_key});
            chk("key_valid", {7'h0, key_valid}, {7'h0, m_valid});
            chk("key_held", {7'h0, key_held}, {7'h0, m_held});
`ifdef KEYPAD_HISTORY_EN
            chk("prev_key", {4'h0, prev_key}, {4'h0, m_prev});
`endif
            if (key_valid === 1'b1) pulses++;
        end
    end

    task automatic wait_pulse(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_valid !== 1'b1 && n < budget);
        if (key_valid !== 1'b1) chk(name, 8'd0, 8'd1);
    endtask

    task automatic wait_release(input int budget, input string name);
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (key_held !== 1'b0) chk(name, 8'd0, 8'd1);
    endtask

    initial begin
        int p0, n;
        reset = 1'b0; pressed = 16'h0; glitch = 1'b0; run = 1'b0;
        #1 reset = 1'b1;
        run = 1'b1;
        @(negedge clk);
        chk("reset rows_n", {4'h0, rows_n}, 8'h0E);
        chk("reset key", {4'h0, key}, 8'h00);
        chk("reset key_held", {7'h0, key_held}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle scanning: one row step per SD clocks, no pulses.
        repeat (4) @(negedge clk);
        chk("idle step1 rows_n", {4'h0, rows_n}, 8'h0D);
        repeat (4) @(negedge clk);
        chk("idle step2 rows_n", {4'h0, rows_n}, 8'h0B);
        repeat (4) @(negedge clk);
        chk("idle step3 rows_n", {4'h0, rows_n}, 8'h07);
        repeat (4) @(negedge clk);
        chk("idle wrap rows_n", {4'h0, rows_n}, 8'h0E);
        repeat (24) @(negedge clk);
        chk("idle pulses", 8'(pulses), 8'd0);

        // Steady key 6 (row 1, col 2).
        pressed[6] = 1'b1;
        wait_pulse(200, "key6 pulse timeout");
        chk("key6 code", {4'h0, key}, 8'h06);
        chk("key6 held", {7'h0, key_held}, 8'h01);
        chk("key6 rows frozen", {4'h0, rows_n}, 8'h0D);
        repeat (40) @(negedge clk);
        chk("key6 single pulse", 8'(pulses), 8'd1);
        chk("key6 rows still frozen", {4'h0, rows_n}, 8'h0D);

        // Second key (row 3, col 1) while holding: ignored.
        pressed[13] = 1'b1;
        repeat (40) @(negedge clk);
        chk("second key ignored", 8'(pulses), 8'd1);
        pressed = 16'h0;
        wait_release(100, "release timeout");
        chk("key kept after release", {4'h0, key}, 8'h06);
        repeat (20) @(negedge clk);

        // Bounce during press debounce: first attempt aborted.
        pressed[6] = 1'b1;
        n = 0;
        while (m_streak != 1 && n < 200) begin @(negedge clk); n++; end
        if (m_streak != 1) chk("bounce arm timeout", 8'd0, 8'd1);
        p0 = pulses;
        glitch = 1'b1;
        repeat (4) @(negedge clk);
        glitch = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce no pulse", 8'(pulses), 8'(p0));
        wait_pulse(200, "bounce retry timeout");
        chk("bounce retry key", {4'h0, key}, 8'h06);
        pressed = 16'h0;
        wait_release(100, "bounce release timeout");

        // Two columns low on row 2: not a key.
        p0 = pulses;
        pressed[8] = 1'b1; pressed[9] = 1'b1;
        repeat (80) @(negedge clk);
        chk("double col no pulse", 8'(pulses), 8'(p0));
        chk("double col not held", {7'h0, key_held}, 8'h00);
        pressed = 16'h0;
        repeat (12) @(negedge clk);

        // Key 2 then key A: history.
        pressed[1] = 1'b1;
        wait_pulse(200, "key2 timeout");
        chk("key2 code", {4'h0, key}, 8'h02);
        pressed = 16'h0;
        wait_release(100, "key2 release timeout");
        repeat (8) @(negedge clk);
        pressed[3] = 1'b1;
        wait_pulse(200, "keyA timeout");
        chk("keyA code", {4'h0, key}, 8'h0A);
`ifdef KEYPAD_HISTORY_EN
        chk("keyA prev_key", {4'h0, prev_key}, 8'h02);
`endif

        // Reset asserted during release debounce.
        repeat (8) @(negedge clk);
        pressed = 16'h0;
        n = 0;
        while (m_rel < 1 && n < 100) begin @(negedge clk); n++; end
        if (m_rel < 1) chk("deb_rel arm timeout", 8'd0, 8'd1);
        chk("pre-reset held", {7'h0, key_held}, 8'h01);
        reset = 1'b1;
        #1;
        chk("async reset held", {7'h0, key_held}, 8'h00);
        chk("async reset key", {4'h0, key}, 8'h00);
        chk("async reset rows_n", {4'h0, rows_n}, 8'h0E);
        chk("async reset valid", {7'h0, key_valid}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        run = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
